// File: rtl/skolem_check_bvuge_bvneg_pkg.sv
// Shared types and defaults for the bvuge/bvneg Skolem checker.
// Optional capture of the first failing point is enabled by SKOLEM_CHECK_CAPTURE_EN.
package skolem_check_bvuge_bvneg_pkg;

  localparam int DEFAULT_W      = 4;
  localparam int DEFAULT_SETTLE = 1;
  localparam int WAIT_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/skolem_check_bvuge_bvneg_eval.sv
// Combinational point check: ok when (-x mod 2^W) >= t, unsigned.
// Kept standalone so other find_inv checkers can reuse it.
module bvuge_bvneg_eval
  import skolem_check_bvuge_bvneg_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] t,
  input  logic [W-1:0] x,
  output logic         ok
);

  logic [W-1:0] w_negX;

  assign w_negX = ~x + W'(1);
  assign ok     = (w_negX >= t);

endmodule

// File: rtl/skolem_check_bvuge_bvneg.sv
// Exhaustive checker driving every t in 0..2^W-1 to an external Skolem function.
// Define SKOLEM_CHECK_CAPTURE_EN to add first_vld/first_t/first_x capture outputs.
module skolem_check_bvuge_bvneg
  import skolem_check_bvuge_bvneg_pkg::*;
#(
  parameter int W      = DEFAULT_W,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [W-1:0] cand_t,
  input  logic [W-1:0] cand_x,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [W:0]   fail_cnt
`ifdef SKOLEM_CHECK_CAPTURE_EN
  ,
  output logic         first_vld,
  output logic [W-1:0] first_t,
  output logic [W-1:0] first_x
`endif
);

  localparam logic [W-1:0]          T_MAX      = '1;
  localparam logic [WAIT_CNT_W-1:0] SETTLE_CNT = WAIT_CNT_W'(SETTLE);

  state_e                  r_state;
  state_e                  w_stateNext;
  logic [WAIT_CNT_W-1:0]   r_waitCnt;
  logic [W-1:0]            r_candT;
  logic [W:0]              r_failCnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic                    w_ok;

  bvuge_bvneg_eval #(
    .W (W)
  ) u_eval (
    .t  (r_candT),
    .x  (cand_x),
    .ok (w_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = WAIT;
      WAIT:    if (r_waitCnt == '0) w_stateNext = CHECK;
      CHECK:   w_stateNext = (r_candT == T_MAX) ? FIN : WAIT;
      FIN:     w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // done and pass are registered out of FIN, so done lands one cycle after the last CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waitCnt <= '0;
      r_candT   <= '0;
      r_failCnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_candT   <= '0;
            r_failCnt <= '0;
            r_pass    <= 1'b0;
            r_waitCnt <= SETTLE_CNT;
            r_busy    <= 1'b1;
          end
        end
        WAIT: begin
          if (r_waitCnt != '0) r_waitCnt <= r_waitCnt - 1'b1;
        end
        CHECK: begin
          if (!w_ok) r_failCnt <= r_failCnt + 1'b1;
          if (r_candT != T_MAX) begin
            r_candT   <= r_candT + 1'b1;
            r_waitCnt <= SETTLE_CNT;
          end
        end
        FIN: begin
          r_done <= 1'b1;
          r_pass <= (r_failCnt == '0);
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign cand_t   = r_candT;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail_cnt = r_failCnt;

`ifdef SKOLEM_CHECK_CAPTURE_EN
  logic         r_firstVld;
  logic [W-1:0] r_firstT;
  logic [W-1:0] r_firstX;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_firstVld <= 1'b0;
      r_firstT   <= '0;
      r_firstX   <= '0;
    end else if (r_state == IDLE && start) begin
      r_firstVld <= 1'b0;
      r_firstT   <= '0;
      r_firstX   <= '0;
    end else if (r_state == CHECK && !w_ok && !r_firstVld) begin
      r_firstVld <= 1'b1;
      r_firstT   <= r_candT;
      r_firstX   <= cand_x;
    end
  end

  assign first_vld = r_firstVld;
  assign first_t   = r_firstT;
  assign first_x   = r_firstX;
`endif

endmodule

// File: tb/tb_skolem_check_bvuge_bvneg.sv
// Bench for skolem_check_bvuge_bvneg: table-driven runs scored on done, plus corner sequences.
// Capture outputs are checked when SKOLEM_CHECK_CAPTURE_EN is defined.
module tb_skolem_check_bvuge_bvneg;

  localparam int W    = 4;
  localparam int NPTS = 16;
  localparam int LAT1 = NPTS * 3 + 1;
  localparam int LAT0 = NPTS * 2 + 1;

  typedef struct {
    int mode;
    int expFail;
    bit expPass;
    bit expVld;
    int expFirstT;
    int expFirstX;
  } vec_t;

  typedef struct {
    int expFail;
    bit expPass;
    bit expVld;
    int expFirstT;
    int expFirstX;
    int expLat;
    int acceptCyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] cand_t;
  logic [W-1:0] cand_x;
  logic         busy;
  logic         done;
  logic         pass;
  logic [W:0]   fail_cnt;

  logic         start0;
  logic [W-1:0] cand_t0;
  logic [W-1:0] cand_x0;
  logic         busy0;
  logic         done0;
  logic         pass0;
  logic [W:0]   fail_cnt0;

`ifdef SKOLEM_CHECK_CAPTURE_EN
  logic         first_vld;
  logic [W-1:0] first_t;
  logic [W-1:0] first_x;
  logic         first_vld0;
  logic [W-1:0] first_t0;
  logic [W-1:0] first_x0;
`endif

  int   nCompared   = 0;
  int   nMismatched = 0;
  int   cyc         = 0;
  int   mode        = 0;
  exp_t sbQ[$];
  exp_t monE;
  vec_t vecs[5];

  always #5 clk = ~clk;

  skolem_check_bvuge_bvneg #(.W(W), .SETTLE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cand_t   (cand_t),
    .cand_x   (cand_x),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_cnt (fail_cnt)
`ifdef SKOLEM_CHECK_CAPTURE_EN
    ,
    .first_vld(first_vld),
    .first_t  (first_t),
    .first_x  (first_x)
`endif
  );

  skolem_check_bvuge_bvneg #(.W(W), .SETTLE(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start0),
    .cand_t   (cand_t0),
    .cand_x   (cand_x0),
    .busy     (busy0),
    .done     (done0),
    .pass     (pass0),
    .fail_cnt (fail_cnt0)
`ifdef SKOLEM_CHECK_CAPTURE_EN
    ,
    .first_vld(first_vld0),
    .first_t  (first_t0),
    .first_x  (first_x0)
`endif
  );

  // Emulated Skolem functions: 0 x=1, 1 x=0, 2 x=~t, 3 x=-t, 4 x=5t+3.
  function automatic logic [W-1:0] xFor(input int m, input logic [W-1:0] t);
    case (m)
      0:       return W'(1);
      1:       return W'(0);
      2:       return ~t;
      3:       return W'(0 - int'(t));
      default: return W'((int'(t) * 5 + 3) % NPTS);
    endcase
  endfunction

  always_comb cand_x = xFor(mode, cand_t);
  assign cand_x0 = W'(1);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nCompared++;
    if (act !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard consumer: each done pulse must match the oldest outstanding run.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (done) begin
      if (sbQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("latency", cyc - monE.acceptCyc, monE.expLat);
        checkOutput("fail_cnt", 32'(fail_cnt), monE.expFail);
        checkOutput("pass", 32'(pass), 32'(monE.expPass));
        checkOutput("busy_at_done", 32'(busy), 0);
`ifdef SKOLEM_CHECK_CAPTURE_EN
        checkOutput("first_vld", 32'(first_vld), 32'(monE.expVld));
        if (monE.expVld) begin
          checkOutput("first_t", 32'(first_t), monE.expFirstT);
          checkOutput("first_x", 32'(first_x), monE.expFirstX);
        end
`endif
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    mode  = v.mode;
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    e.expFail   = v.expFail;
    e.expPass   = v.expPass;
    e.expVld    = v.expVld;
    e.expFirstT = v.expFirstT;
    e.expFirstX = v.expFirstX;
    e.expLat    = LAT1;
    e.acceptCyc = cyc;
    sbQ.push_back(e);
    checkOutput("busy_after_accept", 32'(busy), 1);
  endtask

  task automatic waitRun(input int limit);
    int n = 0;
    while (sbQ.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sbQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected done", limit);
      sbQ.delete();
    end
  endtask

  initial begin
    int   n;
    int   k;
    bit   seen;
    vec_t good;

    vecs[0] = '{0, 0,  1'b1, 1'b0, 0,  0};
    vecs[1] = '{1, 15, 1'b0, 1'b1, 1,  0};
    vecs[2] = '{2, 1,  1'b0, 1'b1, 15, 0};
    vecs[3] = '{3, 0,  1'b1, 1'b0, 0,  0};
    vecs[4] = '{4, 8,  1'b0, 1'b1, 5,  12};
    good    = vecs[0];

    rst    = 1'b1;
    start  = 1'b0;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_pass", 32'(pass), 0);
    checkOutput("reset_fail_cnt", 32'(fail_cnt), 0);
    checkOutput("reset_cand_t", 32'(cand_t), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      waitRun(200);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pass_held", 32'(pass), 32'(vecs[i].expPass));
      checkOutput("fail_cnt_held", 32'(fail_cnt), vecs[i].expFail);
    end

    // A second start 5 cycles into a run must be ignored.
    applyStimulus(vecs[2]);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitRun(200);
    repeat (60) @(posedge clk);

    // Reset at point t=7 aborts a failing run with no done.
    applyStimulus(vecs[1]);
    n = 0;
    while (cand_t != W'(7) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL reach_t7: got cand_t=%0d, expected 7", cand_t);
    end
    checkOutput("fail_cnt_at_t7", 32'(fail_cnt), 6);
    rst = 1'b1;
    sbQ.delete();
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_pass", 32'(pass), 0);
    checkOutput("abort_fail_cnt", 32'(fail_cnt), 0);
    checkOutput("abort_cand_t", 32'(cand_t), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    applyStimulus(good);
    waitRun(200);

    // SETTLE=0 instance: one point every 2 cycles, done after 33.
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    k      = 0;
    seen   = 1'b0;
    while (!seen && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 2 || k == 9 || k == 30) checkOutput("settle0_cand_t", 32'(cand_t0), k / 2);
      if (done0) seen = 1'b1;
    end
    checkOutput("settle0_latency", k, LAT0);
    checkOutput("settle0_pass", 32'(pass0), 1);
    checkOutput("settle0_fail_cnt", 32'(fail_cnt0), 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000, expected earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
